// File: rtl/sum_window_if.sv
// Handshake bundle between the adder stage, the window accumulator and the
// downstream output mux. slave = accumulator side, master = producer/consumer side.
interface sum_window_if #(
  parameter int DATA_W   = 8,
  parameter int LOG2_WIN = 2
);
  localparam int SUM_W = DATA_W + 1 + LOG2_WIN;
  localparam int CNT_W = LOG2_WIN + 1;

  logic [DATA_W-1:0] in_data;
  logic              in_carry;
  logic              in_valid;
  logic              in_ready;
  logic              flush;
  logic [SUM_W-1:0]  out_sum;
  logic [DATA_W:0]   out_mean;
  logic [CNT_W-1:0]  out_count;
  logic              out_partial;
  logic              out_valid;
  logic              out_ready;

  modport slave (
    input  in_data, in_carry, in_valid, flush, out_ready,
    output in_ready, out_sum, out_mean, out_count, out_partial, out_valid
  );

  modport master (
    output in_data, in_carry, in_valid, flush, out_ready,
    input  in_ready, out_sum, out_mean, out_count, out_partial, out_valid
  );
endinterface

// File: rtl/sum_window_accumulator.sv
// Accumulates fixed windows of 2^LOG2_WIN adder sums ({carry, sum}) and emits
// the window total and mean through a single registered valid/ready slot.
// A flush closes a partial window early; if the output slot is busy the flush
// is remembered and fires as soon as the slot frees up.
module sum_window_accumulator #(
  parameter int DATA_W   = 8,
  parameter int LOG2_WIN = 2
) (
  input  logic         clk,
  input  logic         rst,
  sum_window_if.slave  bus
);
  localparam int WIN   = 1 << LOG2_WIN;
  localparam int OP_W  = DATA_W + 1;
  localparam int SUM_W = DATA_W + 1 + LOG2_WIN;
  localparam int CNT_W = LOG2_WIN + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIN - 1);

  logic [SUM_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             flush_pend_q, flush_pend_d;
  logic [SUM_W-1:0] out_sum_q, out_sum_d;
  logic [OP_W-1:0]  out_mean_q, out_mean_d;
  logic [CNT_W-1:0] out_count_q, out_count_d;
  logic             out_partial_q, out_partial_d;
  logic             out_valid_q, out_valid_d;

  logic             free, in_rdy, beat, req, full_close, flush_close, close;
  logic [SUM_W-1:0] operand, sum_new;
  logic [CNT_W-1:0] cnt_new;

  // Handshake, window-close decisions and next state for all registers.
  always_comb begin
    // Output slot is empty or is being drained this cycle.
    free        = !out_valid_q || bus.out_ready;
    // Only the window-completing beat needs a free slot; it never looks at in_valid.
    in_rdy      = free || (cnt_q != LAST);
    beat        = bus.in_valid && in_rdy;
    operand     = SUM_W'({bus.in_carry, bus.in_data});
    sum_new     = acc_q + (beat ? operand : '0);
    cnt_new     = cnt_q + CNT_W'(beat);
    req         = bus.flush || flush_pend_q;
    full_close  = beat && (cnt_q == LAST);
    // cnt_new cannot wrap (max WIN fits CNT_W), so nonzero means non-empty.
    flush_close = req && (cnt_new != '0) && free;
    close       = full_close || flush_close;

    acc_d         = close ? '0 : sum_new;
    cnt_d         = close ? '0 : cnt_new;
    // Keep the request only while it is waiting on a busy output slot;
    // an empty window simply drops it.
    flush_pend_d  = req && (cnt_new != '0) && !close;

    out_sum_d     = out_sum_q;
    out_mean_d    = out_mean_q;
    out_count_d   = out_count_q;
    out_partial_d = out_partial_q;
    out_valid_d   = out_valid_q;
    if (close) begin
      // Reload even while draining: back-to-back results without a bubble.
      out_sum_d     = sum_new;
      out_mean_d    = sum_new[SUM_W-1:LOG2_WIN];
      out_count_d   = cnt_new;
      out_partial_d = !full_close;
      out_valid_d   = 1'b1;
    end else if (bus.out_ready) begin
      out_valid_d   = 1'b0;
    end
  end

  // State registers with synchronous reset that discards any held result.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q         <= '0;
      cnt_q         <= '0;
      flush_pend_q  <= 1'b0;
      out_sum_q     <= '0;
      out_mean_q    <= '0;
      out_count_q   <= '0;
      out_partial_q <= 1'b0;
      out_valid_q   <= 1'b0;
    end else begin
      acc_q         <= acc_d;
      cnt_q         <= cnt_d;
      flush_pend_q  <= flush_pend_d;
      out_sum_q     <= out_sum_d;
      out_mean_q    <= out_mean_d;
      out_count_q   <= out_count_d;
      out_partial_q <= out_partial_d;
      out_valid_q   <= out_valid_d;
    end
  end

  assign bus.in_ready    = in_rdy;
  assign bus.out_sum     = out_sum_q;
  assign bus.out_mean    = out_mean_q;
  assign bus.out_count   = out_count_q;
  assign bus.out_partial = out_partial_q;
  assign bus.out_valid   = out_valid_q;
endmodule
